fetch_issue_unit: RTL and testbench

//  Parametrised instruction fetch/issue front end. Requests one cache line at a time from the instruction cache.

---
 rtl/fetch_pkg.sv | 50 +++++
 rtl/fetch_decode.sv | 78 +++++++
 rtl/fetch_issue_unit.sv | 278 +++++++++++++++++++++++++++
 tb/tb_fetch_issue_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch/issue front end: opcode encodings
// (top 4 bits of every instruction word), RS unit codes, decoded
// instruction kinds, the FSM state encoding and the "value ready" tag helper.
// ---------------------------------------------------------------------------
package fetch_pkg;

  // Opcodes, inst[WORD_W-1 -: 4]
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_HALT = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_BGT  = 4'b1010;
  localparam logic [3:0] OP_LW   = 4'b1100;
  localparam logic [3:0] OP_SW   = 4'b1101;
  localparam logic [3:0] OP_JMP  = 4'b1110;
  localparam logic [3:0] OP_MV   = 4'b1111;

  // Reservation-station unit codes carried on iss_unit
  localparam logic [2:0] UNIT_LW   = 3'd0;
  localparam logic [2:0] UNIT_SW   = 3'd1;
  localparam logic [2:0] UNIT_ADD  = 3'd2;
  localparam logic [2:0] UNIT_MUL  = 3'd3;
  localparam logic [2:0] UNIT_MV   = 3'd4;
  localparam logic [2:0] UNIT_HALT = 3'd5;

  // What the front end does with a decoded word
  typedef enum logic [1:0] {
    KIND_SKIP  = 2'd0,   // NOP and unknown opcodes
    KIND_ISSUE = 2'd1,   // ALU/MUL/LD/ST/MV/HALT go to the RS
    KIND_JMP   = 2'd2,
    KIND_BGT   = 2'd3
  } kind_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_ISSUE  = 3'd2,
    S_BRA_A  = 3'd3,
    S_BRA_B  = 3'd4,
    S_HALTED = 3'd5
  } state_e;

  // TAG_READY: all ones except the MSB (0x7F for an 8-bit tag).
  function automatic logic [31:0] tag_ready(input int tag_w);
    return (32'd1 << (tag_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fetch_decode.sv
// ---------------------------------------------------------------------------
// fetch_decode
// Purely combinational decode of one instruction word. Field positions are
// fixed to the 32-bit layout (requires WORD_W >= 32); the opcode is always
// the top 4 bits of the word.
// Ports:
//   inst    in   WORD_W  instruction word
//   kind    out  kind_e  skip / issue / jump / branch
//   unit    out  3       RS unit code (valid for KIND_ISSUE)
//   r1..r3  out  REG_W   register fields [27:22], [21:16], [15:10]
//   hasimm  out  1       immediate form (inst[0]) for ALU/MEM/MV
//   imm     out  WORD_W  sign-extended immediate (0 when not immediate form)
//   offset  out  WORD_W  sign-extended inst[27:0], jump/branch displacement
// ---------------------------------------------------------------------------
module fetch_decode
  import fetch_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_W  = 6
) (
  input  logic [WORD_W-1:0] inst,
  output kind_e             kind,
  output logic [2:0]        unit,
  output logic [REG_W-1:0]  r1,
  output logic [REG_W-1:0]  r2,
  output logic [REG_W-1:0]  r3,
  output logic              hasimm,
  output logic [WORD_W-1:0] imm,
  output logic [WORD_W-1:0] offset
);

  logic [3:0] opcode;

  assign opcode = inst[WORD_W-1 -: 4];
  assign offset = WORD_W'($signed(inst[27:0]));

  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves a value unassigned, which would otherwise infer a latch.
    kind   = KIND_SKIP;
    unit   = '0;
    r1     = '0;
    r2     = '0;
    r3     = '0;
    hasimm = 1'b0;
    imm    = '0;

    case (opcode)
      OP_LW:   begin kind = KIND_ISSUE; unit = UNIT_LW;   end
      OP_SW:   begin kind = KIND_ISSUE; unit = UNIT_SW;   end
      OP_ADD:  begin kind = KIND_ISSUE; unit = UNIT_ADD;  end
      OP_MUL:  begin kind = KIND_ISSUE; unit = UNIT_MUL;  end
      OP_MV:   begin kind = KIND_ISSUE; unit = UNIT_MV;   end
      OP_HALT: begin kind = KIND_ISSUE; unit = UNIT_HALT; end
      OP_JMP:  kind = KIND_JMP;
      OP_BGT:  kind = KIND_BGT;
      default: kind = KIND_SKIP;
    endcase

    if (opcode inside {OP_LW, OP_SW, OP_ADD, OP_MUL}) begin
      // The 15-bit immediate overlaps the r3 field; both are presented.
      r1     = REG_W'(inst[27:22]);
      r2     = REG_W'(inst[21:16]);
      r3     = REG_W'(inst[15:10]);
      hasimm = inst[0];
      if (inst[0]) imm = WORD_W'($signed(inst[15:1]));
    end else if (opcode == OP_MV) begin
      r1     = REG_W'(inst[27:22]);
      hasimm = inst[0];
      if (inst[0]) imm = WORD_W'($signed(inst[21:1]));
      else         r2  = REG_W'(inst[21:16]);
    end else if (opcode == OP_BGT) begin
      r1 = REG_W'(inst[27:22]);
      r2 = REG_W'(inst[21:16]);
    end
  end

endmodule

// File: rtl/fetch_issue_unit.sv
// ---------------------------------------------------------------------------
// fetch_issue_unit
// Instruction fetch/issue front end between the instruction cache and the
// reservation-station complex. Fetches one line, walks it word by word
// (word 0 in the top bits of ic_line), issues ALU/MUL/LD/ST/MV/HALT over a
// valid/ready handshake, resolves JMP and BGT locally (BGT reads two
// registers through rf_addr/rf_tag/rf_val) and stops for good on HALT.
// Optional feature macro: FETCH_PERF_EN adds four saturating 32-bit
// performance counters (issues, icache wait, RS wait, taken jumps/branches).
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   ic_addr          line-aligned fetch address (driven only in FETCH)
//   ic_hit, ic_line  line for ic_addr is present this cycle
//   iss_valid/ready  issue handshake; iss_unit/r1/r2/r3/hasimm/imm fields
//   rf_addr          register index for BGT operand reads
//   rf_tag, rf_val   producer tag (ready when == TAG_READY) and value
//   pc               byte address of the word under decode
//   halted           HALT issued; unit idle until rst
//   perf_*           (FETCH_PERF_EN only) event counters
// ---------------------------------------------------------------------------
module fetch_issue_unit
  import fetch_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 32,
  parameter int REG_W      = 6,
  parameter int TAG_W      = 8,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [WORD_W-1:0]            ic_addr,
  input  logic                         ic_hit,
  input  logic [LINE_WORDS*WORD_W-1:0] ic_line,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [2:0]                   iss_unit,
  output logic [REG_W-1:0]             iss_r1,
  output logic [REG_W-1:0]             iss_r2,
  output logic [REG_W-1:0]             iss_r3,
  output logic                         iss_hasimm,
  output logic [WORD_W-1:0]            iss_imm,
  output logic [REG_W-1:0]             rf_addr,
  input  logic [TAG_W-1:0]             rf_tag,
  input  logic [WORD_W-1:0]            rf_val,
  output logic [WORD_W-1:0]            pc,
  output logic                         halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                  perf_issued,
  output logic [31:0]                  perf_stall_ic,
  output logic [31:0]                  perf_stall_rs,
  output logic [31:0]                  perf_taken
`endif
);

  localparam int WORD_BYTES = WORD_W / 8;
  localparam int LINE_BYTES = LINE_WORDS * WORD_BYTES;
  localparam int OFF_LSB    = $clog2(WORD_BYTES);
  localparam int OFF_W      = $clog2(LINE_WORDS);
  localparam logic [WORD_W-1:0] LINE_MASK  = WORD_W'(LINE_BYTES - 1);
  localparam logic [WORD_W-1:0] WORD_MASK  = WORD_W'(WORD_BYTES - 1);
  localparam logic [WORD_W-1:0] WORD_STEP  = WORD_W'(WORD_BYTES);
  localparam logic [OFF_W-1:0]  LAST_IDX   = OFF_W'(LINE_WORDS - 1);
  localparam logic [TAG_W-1:0]  TAG_READY  = TAG_W'(tag_ready(TAG_W));

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  pc_d;
  logic [OFF_W-1:0]   widx_q, widx_d;
  logic [WORD_W-1:0]  line_q [LINE_WORDS];
  logic [REG_W-1:0]   br_r1_q, br_r2_q;
  logic [WORD_W-1:0]  br_off_q;
  logic [WORD_W-1:0]  a_q;

  logic load_line, load_iss, clr_iss, load_br, load_a;
  logic rf_ok, br_gt;

  logic [WORD_W-1:0] line_base, adv_pc, jmp_target, br_target;
  state_e            adv_state;

  kind_e             dec_kind;
  logic [2:0]        dec_unit;
  logic [REG_W-1:0]  dec_r1, dec_r2, dec_r3;
  logic              dec_hasimm;
  logic [WORD_W-1:0] dec_imm, dec_offset;

  fetch_decode #(.WORD_W(WORD_W), .REG_W(REG_W)) u_decode (
    .inst   (line_q[widx_q]),
    .kind   (dec_kind),
    .unit   (dec_unit),
    .r1     (dec_r1),
    .r2     (dec_r2),
    .r3     (dec_r3),
    .hasimm (dec_hasimm),
    .imm    (dec_imm),
    .offset (dec_offset)
  );

  // Targets are relative to the base of the line holding the jump/branch;
  // sub-word target bits are dropped.
  assign line_base  = pc & ~LINE_MASK;
  assign adv_pc     = pc + WORD_STEP;
  assign adv_state  = (widx_q == LAST_IDX) ? S_FETCH : S_DECODE;
  assign jmp_target = (line_base + dec_offset) & ~WORD_MASK;
  assign br_target  = (line_base + br_off_q) & ~WORD_MASK;
  assign rf_ok      = (rf_tag == TAG_READY);
  assign br_gt      = ($signed(a_q) > $signed(rf_val));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc;
    widx_d    = widx_q;
    load_line = 1'b0;
    load_iss  = 1'b0;
    clr_iss   = 1'b0;
    load_br   = 1'b0;
    load_a    = 1'b0;
    ic_addr   = '0;
    iss_valid = 1'b0;
    rf_addr   = '0;
    halted    = 1'b0;

    case (state_q)
      S_FETCH: begin
        ic_addr = line_base;
        if (ic_hit) begin
          load_line = 1'b1;
          widx_d    = pc[OFF_LSB +: OFF_W];
          state_d   = S_DECODE;
        end
      end

      S_DECODE: begin
        case (dec_kind)
          KIND_ISSUE: begin
            load_iss = 1'b1;
            state_d  = S_ISSUE;
          end
          KIND_JMP: begin
            pc_d    = jmp_target;
            state_d = S_FETCH;
          end
          KIND_BGT: begin
            load_br = 1'b1;
            state_d = S_BRA_A;
          end
          default: begin
            pc_d    = adv_pc;
            widx_d  = widx_q + OFF_W'(1);
            state_d = adv_state;
          end
        endcase
      end

      S_ISSUE: begin
        iss_valid = 1'b1;
        if (iss_ready) begin
          clr_iss = 1'b1;
          if (iss_unit == UNIT_HALT) begin
            state_d = S_HALTED;
          end else begin
            pc_d    = adv_pc;
            widx_d  = widx_q + OFF_W'(1);
            state_d = adv_state;
          end
        end
      end

      S_BRA_A: begin
        rf_addr = br_r1_q;
        if (rf_ok) begin
          load_a  = 1'b1;
          state_d = S_BRA_B;
        end
      end

      S_BRA_B: begin
        rf_addr = br_r2_q;
        if (rf_ok) begin
          if (br_gt) begin
            pc_d    = br_target;
            state_d = S_FETCH;
          end else begin
            pc_d    = adv_pc;
            widx_d  = widx_q + OFF_W'(1);
            state_d = adv_state;
          end
        end
      end

      S_HALTED: halted = 1'b1;

      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: the line buffer has no reset; it is always reloaded in FETCH
  // before any word of it is decoded, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (load_line) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        line_q[i] <= ic_line[(LINE_WORDS-1-i)*WORD_W +: WORD_W];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc         <= RESET_PC;
      widx_q     <= '0;
      iss_unit   <= '0;
      iss_r1     <= '0;
      iss_r2     <= '0;
      iss_r3     <= '0;
      iss_hasimm <= 1'b0;
      iss_imm    <= '0;
      br_r1_q    <= '0;
      br_r2_q    <= '0;
      br_off_q   <= '0;
      a_q        <= '0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      widx_q  <= widx_d;
      // Issue fields are held through the whole ISSUE wait and zeroed
      // on acceptance so the bus is quiet outside ISSUE.
      if (load_iss) begin
        iss_unit   <= dec_unit;
        iss_r1     <= dec_r1;
        iss_r2     <= dec_r2;
        iss_r3     <= dec_r3;
        iss_hasimm <= dec_hasimm;
        iss_imm    <= dec_imm;
      end else if (clr_iss) begin
        iss_unit   <= '0;
        iss_r1     <= '0;
        iss_r2     <= '0;
        iss_r3     <= '0;
        iss_hasimm <= 1'b0;
        iss_imm    <= '0;
      end
      if (load_br) begin
        br_r1_q  <= dec_r1;
        br_r2_q  <= dec_r2;
        br_off_q <= dec_offset;
      end
      if (load_a) a_q <= rf_val;
    end
  end

`ifdef FETCH_PERF_EN
  logic perf_take;
  assign perf_take = ((state_q == S_DECODE) && (dec_kind == KIND_JMP)) ||
                     ((state_q == S_BRA_B) && rf_ok && br_gt);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued   <= '0;
      perf_stall_ic <= '0;
      perf_stall_rs <= '0;
      perf_taken    <= '0;
    end else begin
      if (iss_valid && iss_ready && (perf_issued != '1))
        perf_issued <= perf_issued + 32'd1;
      if ((state_q == S_FETCH) && !ic_hit && (perf_stall_ic != '1))
        perf_stall_ic <= perf_stall_ic + 32'd1;
      if ((state_q == S_ISSUE) && !iss_ready && (perf_stall_rs != '1))
        perf_stall_rs <= perf_stall_rs + 32'd1;
      if (perf_take && (perf_taken != '1))
        perf_taken <= perf_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_issue_unit
// Directed bench for fetch_issue_unit with default parameters
// (32-bit words, 32-word / 128-byte lines, TAG_READY = 0x7F).
// ---------------------------------------------------------------------------
module tb_fetch_issue_unit;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   ic_addr;
  logic          ic_hit;
  logic [1023:0] ic_line;
  logic          iss_valid;
  logic          iss_ready;
  logic [2:0]    iss_unit;
  logic [5:0]    iss_r1, iss_r2, iss_r3;
  logic          iss_hasimm;
  logic [31:0]   iss_imm;
  logic [5:0]    rf_addr;
  logic [7:0]    rf_tag;
  logic [31:0]   rf_val;
  logic [31:0]   pc;
  logic          halted;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_issued, perf_stall_ic, perf_stall_rs, perf_taken;
`endif

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_halt_acc = 0;

  logic [31:0] words [32];

  fetch_issue_unit dut (
    .clk        (clk),
    .rst        (rst),
    .ic_addr    (ic_addr),
    .ic_hit     (ic_hit),
    .ic_line    (ic_line),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_unit   (iss_unit),
    .iss_r1     (iss_r1),
    .iss_r2     (iss_r2),
    .iss_r3     (iss_r3),
    .iss_hasimm (iss_hasimm),
    .iss_imm    (iss_imm),
    .rf_addr    (rf_addr),
    .rf_tag     (rf_tag),
    .rf_val     (rf_val),
    .pc         (pc),
    .halted     (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_issued   (perf_issued),
    .perf_stall_ic (perf_stall_ic),
    .perf_stall_rs (perf_stall_rs),
    .perf_taken    (perf_taken)
`endif
  );

  always #5 clk = ~clk;

  // Handshake monitor: accepted issues, and accepted HALTs separately.
  always @(posedge clk) begin
    if (!rst && iss_valid && iss_ready) begin
      n_acc++;
      if (iss_unit == 3'd5) n_halt_acc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_hold();
    rst = 1'b1;
    step();
  endtask

  task automatic clear_words();
    for (int i = 0; i < 32; i++) words[i] = 32'h0;
  endtask

  task automatic pack_line();
    for (int i = 0; i < 32; i++) ic_line[(31-i)*32 +: 32] = words[i];
  endtask

  function automatic logic [31:0] enc_r(input logic [3:0] op, input logic [5:0] a,
                                        input logic [5:0] b, input logic [5:0] c);
    return {op, a, b, c, 10'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [3:0] op, input logic [5:0] a,
                                        input logic [5:0] b, input logic [14:0] imm);
    return {op, a, b, imm, 1'b1};
  endfunction

  function automatic logic [31:0] enc_mvi(input logic [5:0] a, input logic [20:0] imm);
    return {4'hF, a, imm, 1'b1};
  endfunction

  function automatic logic [31:0] enc_bgt(input logic [5:0] a, input logic [5:0] b,
                                          input logic [15:0] low);
    return {4'hA, a, b, low};
  endfunction

  localparam logic [31:0] HALT_W = 32'h1000_0000;

  int base_acc;
  int base_halt;
  int n;

  initial begin
    rst       = 1'b1;
    ic_hit    = 1'b0;
    iss_ready = 1'b0;
    rf_tag    = 8'h00;
    rf_val    = 32'h0;
    clear_words();
    pack_line();
    step();
    step();

    // Reset state
    check("rst_pc",       64'(pc),        64'h0);
    check("rst_valid",    64'(iss_valid), 64'h0);
    check("rst_halted",   64'(halted),    64'h0);
    check("rst_rf_addr",  64'(rf_addr),   64'h0);
    check("rst_ic_addr",  64'(ic_addr),   64'h0);
    check("rst_iss_unit", 64'(iss_unit),  64'h0);

    // 1: ADD r1,r2,#5 at word 0, issue in the third cycle after reset
    words[0]  = enc_i(4'h8, 6'd1, 6'd2, 15'd5);
    pack_line();
    ic_hit    = 1'b1;
    iss_ready = 1'b1;
    rst       = 1'b0;
    step();
    check("t1_c2_valid", 64'(iss_valid), 64'h0);
    step();
    check("t1_valid",  64'(iss_valid),  64'h1);
    check("t1_unit",   64'(iss_unit),   64'h2);
    check("t1_r1",     64'(iss_r1),     64'h1);
    check("t1_r2",     64'(iss_r2),     64'h2);
    check("t1_imm",    64'(iss_imm),    64'h5);
    check("t1_hasimm", 64'(iss_hasimm), 64'h1);
    step();
    check("t1_after_valid", 64'(iss_valid), 64'h0);
    check("t1_after_pc",    64'(pc),        64'h4);

    // 2: MUL r3,r4,r5 held four cycles by iss_ready low
    reset_hold();
    clear_words();
    words[0]  = enc_r(4'h9, 6'd3, 6'd4, 6'd5);
    pack_line();
    iss_ready = 1'b0;
    base_acc  = n_acc;
    rst       = 1'b0;
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      check("t2_valid",  64'(iss_valid),  64'h1);
      check("t2_unit",   64'(iss_unit),   64'h3);
      check("t2_r1",     64'(iss_r1),     64'h3);
      check("t2_r2",     64'(iss_r2),     64'h4);
      check("t2_r3",     64'(iss_r3),     64'h5);
      check("t2_hasimm", 64'(iss_hasimm), 64'h0);
      check("t2_pc",     64'(pc),         64'h0);
      if (k == 3) iss_ready = 1'b1;
      step();
    end
    check("t2_after_valid", 64'(iss_valid), 64'h0);
    check("t2_after_pc",    64'(pc),        64'h4);
    step();
    step();
    step();
    check("t2_issue_count", 64'(n_acc - base_acc), 64'h1);

    // 3: BGT r3,r4 taken after r3 busy; target 0x00C40108
    reset_hold();
    clear_words();
    words[0] = enc_bgt(6'd3, 6'd4, 16'h0108);
    pack_line();
    rf_tag = 8'h00;
    rst    = 1'b0;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      check("t3_busy_rf_addr", 64'(rf_addr), 64'h3);
      check("t3_busy_pc",      64'(pc),      64'h0);
      if (k < 2) step();
    end
    rf_tag = 8'h7F;
    rf_val = 32'd7;
    step();
    check("t3_rf_addr_b", 64'(rf_addr), 64'h4);
    rf_val = 32'hFFFF_FFFE;
    ic_hit = 1'b0;
    step();
    check("t3_pc_target", 64'(pc),        64'h00C4_0108);
    check("t3_ic_addr",   64'(ic_addr),   64'h00C4_0100);
    check("t3_valid",     64'(iss_valid), 64'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_wait_ic_addr", 64'(ic_addr), 64'h00C4_0100);
    end
    clear_words();
    words[0] = HALT_W;
    words[2] = enc_r(4'hD, 6'd9, 6'd10, 6'd11);
    pack_line();
    ic_hit   = 1'b1;
    step();
    step();
    check("t3_entry_valid", 64'(iss_valid), 64'h1);
    check("t3_entry_unit",  64'(iss_unit),  64'h1);
    check("t3_entry_r1",    64'(iss_r1),    64'h9);
    check("t3_entry_r3",    64'(iss_r3),    64'hB);
    check("t3_entry_pc",    64'(pc),        64'h00C4_0108);

    // 4: BGT r3=-1, r4=0 not taken (signed), next word issues
    reset_hold();
    clear_words();
    words[0] = enc_bgt(6'd3, 6'd4, 16'h0040);
    words[1] = enc_r(4'h8, 6'd6, 6'd7, 6'd8);
    pack_line();
    rf_tag = 8'h7F;
    rf_val = 32'hFFFF_FFFF;
    rst    = 1'b0;
    step();
    step();
    check("t4_rf_addr_a", 64'(rf_addr), 64'h3);
    step();
    check("t4_rf_addr_b", 64'(rf_addr), 64'h4);
    rf_val = 32'h0;
    step();
    check("t4_nt_pc",    64'(pc),        64'h4);
    check("t4_nt_valid", 64'(iss_valid), 64'h0);
    step();
    check("t4_next_valid", 64'(iss_valid), 64'h1);
    check("t4_next_unit",  64'(iss_unit),  64'h2);
    check("t4_next_r1",    64'(iss_r1),    64'h6);
    check("t4_next_pc",    64'(pc),        64'h4);

    // 5: 31 NOPs then MV r5,#-3 at word 31, wrap to 0x80
    reset_hold();
    clear_words();
    words[31] = enc_mvi(6'd5, 21'h1F_FFFD);
    pack_line();
    rst = 1'b0;
    n   = 0;
    do begin
      step();
      n++;
    end while (!iss_valid && n < 40);
    check("t5_cycles", 64'(n),          64'd33);
    check("t5_valid",  64'(iss_valid),  64'h1);
    check("t5_unit",   64'(iss_unit),   64'h4);
    check("t5_r1",     64'(iss_r1),     64'h5);
    check("t5_imm",    64'(iss_imm),    64'hFFFF_FFFD);
    check("t5_hasimm", 64'(iss_hasimm), 64'h1);
    check("t5_pc",     64'(pc),         64'h7C);
    step();
    check("t5_wrap_pc",      64'(pc),        64'h80);
    check("t5_wrap_ic_addr", 64'(ic_addr),   64'h80);
    check("t5_wrap_valid",   64'(iss_valid), 64'h0);

    // 6: HALT mid-line, then nothing moves
    reset_hold();
    clear_words();
    words[0] = enc_r(4'h8, 6'd1, 6'd2, 6'd3);
    words[1] = HALT_W;
    words[2] = enc_r(4'h8, 6'd4, 6'd5, 6'd6);
    pack_line();
    base_halt = n_halt_acc;
    rst = 1'b0;
    step();
    step();
    step();
    step();
    check("t6_halt_valid", 64'(iss_valid), 64'h1);
    check("t6_halt_unit",  64'(iss_unit),  64'h5);
    step();
    check("t6_halted",      64'(halted),    64'h1);
    check("t6_halted_vld",  64'(iss_valid), 64'h0);
    check("t6_halted_pc",   64'(pc),        64'h4);
    check("t6_halted_unit", 64'(iss_unit),  64'h0);
    for (int k = 0; k < 6; k++) begin
      ic_hit    = (k % 2 == 0) ? 1'b0 : 1'b1;
      iss_ready = (k % 2 == 0) ? 1'b1 : 1'b0;
      step();
      check("t6_idle_valid",   64'(iss_valid), 64'h0);
      check("t6_idle_halted",  64'(halted),    64'h1);
      check("t6_idle_ic_addr", 64'(ic_addr),   64'h0);
      check("t6_idle_pc",      64'(pc),        64'h4);
    end
    check("t6_halt_count", 64'(n_halt_acc - base_halt), 64'h1);

    // 6b: reset while waiting in BRA_A at word 1
    ic_hit    = 1'b1;
    iss_ready = 1'b1;
    reset_hold();
    check("t6b_halt_cleared", 64'(halted), 64'h0);
    clear_words();
    words[1] = enc_bgt(6'd3, 6'd4, 16'h0000);
    pack_line();
    rf_tag = 8'h00;
    rst    = 1'b0;
    step();
    step();
    step();
    check("t6b_bra_rf_addr", 64'(rf_addr), 64'h3);
    check("t6b_bra_pc",      64'(pc),      64'h4);
    rst = 1'b1;
    step();
    check("t6b_rst_pc",      64'(pc),        64'h0);
    check("t6b_rst_rf_addr", 64'(rf_addr),   64'h0);
    check("t6b_rst_valid",   64'(iss_valid), 64'h0);
    check("t6b_rst_halted",  64'(halted),    64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
